// File: rtl/rah_frame_serializer.sv
// rah_frame_serializer
//   Drain stage of the return path. Pops 48-bit RAH frames from the show-behind
//   egress FIFO and feeds them MSB byte first into the byte-wide UART transmitter
//   using its tx_dv / tx_done handshake. A per-byte watchdog aborts a frame when
//   the transmitter stops answering. Frame and error counters are provided.
//   Optional feature macro: RAH_SERIALIZER_CHECKSUM_EN appends a trailer byte
//   holding the XOR of all frame bytes. Without the macro no trailer logic exists.
module rah_frame_serializer #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int UART_DATA_WIDTH  = 8,
  parameter int TX_TIMEOUT       = 8192
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        f_empty,
  output logic                        rd_en,
  input  logic [RAH_PACKET_WIDTH-1:0] data,
  input  logic                        tx_done,
  output logic                        tx_dv,
  output logic [UART_DATA_WIDTH-1:0]  tx_byte,
  output logic                        busy,
  output logic [15:0]                 frame_cnt,
  output logic [7:0]                  err_cnt
);

  localparam int NBYTES = RAH_PACKET_WIDTH / UART_DATA_WIDTH;
`ifdef RAH_SERIALIZER_CHECKSUM_EN
  localparam int NSEND  = NBYTES + 1;
`else
  localparam int NSEND  = NBYTES;
`endif
  localparam int IDX_W  = $clog2(NSEND + 1);
  localparam int WD_W   = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEND - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TX_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  logic [2:0]                  state_r;
  logic [RAH_PACKET_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]            idx_r;
  logic [WD_W-1:0]             wdog_r;
  logic                        rd_en_r;
  logic                        tx_dv_r;
  logic [UART_DATA_WIDTH-1:0]  tx_byte_r;
  logic                        busy_r;
  logic [15:0]                 frame_cnt_r;
  logic [7:0]                  err_cnt_r;
  logic [UART_DATA_WIDTH-1:0]  next_byte_s;

`ifdef RAH_SERIALIZER_CHECKSUM_EN
  logic [UART_DATA_WIDTH-1:0]  csum_r;

  // XOR of every byte lane of a frame, used as the trailer byte.
  function automatic logic [UART_DATA_WIDTH-1:0] frame_xor(
    input logic [RAH_PACKET_WIDTH-1:0] frame
  );
    logic [UART_DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < NBYTES; i++) begin
      acc = acc ^ frame[i*UART_DATA_WIDTH +: UART_DATA_WIDTH];
    end
    return acc;
  endfunction

  // Checksum snapshot taken when the frame is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= '0;
    end else if (state_r == ST_LATCH) begin
      csum_r <= frame_xor(data);
    end else begin
      csum_r <= csum_r;
    end
  end

  // Byte following the current one: next frame byte, or the trailer after the last frame byte.
  always_comb begin
    next_byte_s = shift_r[RAH_PACKET_WIDTH-UART_DATA_WIDTH-1 -: UART_DATA_WIDTH];
    if (idx_r == IDX_W'(NBYTES - 1)) begin
      next_byte_s = csum_r;
    end else begin
      next_byte_s = shift_r[RAH_PACKET_WIDTH-UART_DATA_WIDTH-1 -: UART_DATA_WIDTH];
    end
  end
`else
  assign next_byte_s = shift_r[RAH_PACKET_WIDTH-UART_DATA_WIDTH-1 -: UART_DATA_WIDTH];
`endif

  // Frame sequencer: fetch, latch, then a SEND/WAIT handshake per byte with watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      idx_r       <= '0;
      wdog_r      <= '0;
      rd_en_r     <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= '0;
      busy_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_dv_r <= 1'b0;
          if (!f_empty) begin
            state_r <= ST_FETCH;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          // Show-behind FIFO: data appears the cycle after the strobe.
          rd_en_r <= 1'b0;
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          shift_r   <= data;
          idx_r     <= '0;
          tx_byte_r <= data[RAH_PACKET_WIDTH-1 -: UART_DATA_WIDTH];
          tx_dv_r   <= 1'b1;
          state_r   <= ST_SEND;
        end
        ST_SEND: begin
          tx_dv_r <= 1'b0;
          wdog_r  <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle still counts as done.
          if (tx_done) begin
            if (idx_r == LAST_IDX) begin
              frame_cnt_r <= frame_cnt_r + 16'd1;
              busy_r      <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              idx_r     <= idx_r + IDX_ONE;
              shift_r   <= shift_r << UART_DATA_WIDTH;
              tx_byte_r <= next_byte_s;
              tx_dv_r   <= 1'b1;
              state_r   <= ST_SEND;
            end
          end else if (wdog_r == WD_LIMIT) begin
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
              err_cnt_r <= err_cnt_r;
            end
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            wdog_r <= wdog_r + WD_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
          tx_dv_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_r;
  assign tx_dv     = tx_dv_r;
  assign tx_byte   = tx_byte_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_rah_frame_serializer.sv
// Directed bench for rah_frame_serializer: FIFO model, UART tx_done responder,
// reset, latency, back-to-back, watchdog, coincident done and checksum cases.
module tb_rah_frame_serializer;

  localparam int TO = 64;
`ifdef RAH_SERIALIZER_CHECKSUM_EN
  localparam int NB_TX = 7;
`else
  localparam int NB_TX = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_empty = 1'b1;
  logic        rd_en;
  logic [47:0] data = 48'd0;
  logic        tx_done = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // FIFO model: writes owned by the stimulus, reads by the monitor.
  logic [47:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int bad_rd = 0;

  // Recorded activity (monitor-owned).
  logic [7:0] byte_q[$];
  int dv_cyc_q[$];
  int rd_cyc_q[$];
  int done_cyc_q[$];
  int rd_total = 0;
  int dv_in_frame = 0;
  int pend = 0;
  int stray_seen = 0;

  // Responder controls (stimulus-owned).
  int resp_delay = 20;
  int sp_frame = -1;
  int sp_idx = -1;
  int sp_delay = 0;
  int stray_cnt = 0;

  rah_frame_serializer #(
    .RAH_PACKET_WIDTH(48),
    .UART_DATA_WIDTH(8),
    .TX_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f_empty(f_empty),
    .rd_en(rd_en),
    .data(data),
    .tx_done(tx_done),
    .tx_dv(tx_dv),
    .tx_byte(tx_byte),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor, FIFO read side and UART responder, all on the falling edge.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (stray_cnt != stray_seen) begin
        tx_done = 1'b1;
        stray_seen++;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_done = 1'b1;
          done_cyc_q.push_back(cyc);
        end
      end
      if (rd_en) begin
        rd_cyc_q.push_back(cyc);
        rd_total++;
        dv_in_frame = 0;
        if (rd_ptr == wr_ptr) begin
          bad_rd++;
        end else begin
          data = fifo_mem[rd_ptr];
          rd_ptr++;
        end
      end
      if (tx_dv) begin
        byte_q.push_back(tx_byte);
        dv_cyc_q.push_back(cyc);
        if (rd_total == sp_frame && dv_in_frame == sp_idx) pend = sp_delay;
        else pend = resp_delay;
        dv_in_frame++;
      end
    end
    f_empty = (rd_ptr == wr_ptr);
  end

  task automatic push(input logic [47:0] frame);
    fifo_mem[wr_ptr] = frame;
    wr_ptr++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(!busy && rd_ptr == wr_ptr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(n < budget), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bb, db, rb, nb, n0, n;
    logic [47:0] f3 [0:2];
    logic [7:0] t2_exp [0:5];
    logic [7:0] t6_exp [0:5];
    t2_exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    t6_exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12, 8'h34};
    f3 = '{48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 48'hC1C2_C3C4_C5C6};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_tx_dv", 64'(tx_dv), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);

    // T1: reset during WAIT of byte 3
    @(posedge clk); #1;
    push(48'h1122_3344_5566);
    n = 0;
    while (byte_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t1_reach_byte3", 64'(n < 200), 64'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_tx_byte", 64'(tx_byte), 64'd0);
    check("t1_rst_busy", 64'(busy), 64'd0);
    check("t1_rst_tx_dv", 64'(tx_dv), 64'd0);
    check("t1_rst_rd_en", 64'(rd_en), 64'd0);
    nb = byte_q.size();
    check("t1_bytes_before", 64'(nb), 64'd4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t1_no_more_dv", 64'(byte_q.size()), 64'(nb));
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd0);

    // T2: single frame, latency and byte order
    bb = byte_q.size(); db = dv_cyc_q.size(); rb = rd_cyc_q.size();
    @(posedge clk); #1;
    n0 = cyc;
    push(48'h0123_4567_89AB);
    wait_drain("t2", 500);
    check("t2_nbytes", 64'(byte_q.size() - bb), 64'(NB_TX));
    for (int i = 0; i < 6; i++) check("t2_byte", 64'(byte_q[bb+i]), 64'(t2_exp[i]));
    check("t2_nrd", 64'(rd_cyc_q.size() - rb), 64'd1);
    check("t2_rd_lat", 64'(rd_cyc_q[rb]), 64'(n0 + 1));
    check("t2_dv_lat", 64'(dv_cyc_q[db]), 64'(n0 + 3));
    check("t2_dv_gap", 64'(dv_cyc_q[db+1]), 64'(dv_cyc_q[db] + 21));
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t2_err_cnt", 64'(err_cnt), 64'd0);

    // T3: three back-to-back frames
    bb = byte_q.size(); rb = rd_cyc_q.size(); n = done_cyc_q.size();
    @(posedge clk); #1;
    push(f3[0]); push(f3[1]); push(f3[2]);
    wait_drain("t3", 1500);
    check("t3_nbytes", 64'(byte_q.size() - bb), 64'(3 * NB_TX));
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 6; i++)
        check("t3_byte", 64'(byte_q[bb + f*NB_TX + i]), 64'(f3[f][47-8*i -: 8]));
    check("t3_nrd", 64'(rd_cyc_q.size() - rb), 64'd3);
    check("t3_gap1", 64'(rd_cyc_q[rb+1]), 64'(done_cyc_q[n + NB_TX - 1] + 2));
    check("t3_gap2", 64'(rd_cyc_q[rb+2]), 64'(done_cyc_q[n + 2*NB_TX - 1] + 2));
    check("t3_frame_cnt", 64'(frame_cnt), 64'd4);

    // T4: watchdog abort on byte 2, next frame restarts at byte 0
    bb = byte_q.size(); db = dv_cyc_q.size(); rb = rd_cyc_q.size();
    @(posedge clk); #1;
    sp_frame = rd_total + 1; sp_idx = 2; sp_delay = 0;
    push(48'hD1D2_D3D4_D5D6); push(48'hE1E2_E3E4_E5E6);
    wait_drain("t4", 1500);
    check("t4_nbytes", 64'(byte_q.size() - bb), 64'(3 + NB_TX));
    check("t4_last_d", 64'(byte_q[bb+2]), 64'hD3);
    check("t4_first_e", 64'(byte_q[bb+3]), 64'hE1);
    check("t4_last_e", 64'(byte_q[bb+8]), 64'hE6);
    check("t4_abort_time", 64'(rd_cyc_q[rb+1]), 64'(dv_cyc_q[db+2] + TO + 2));
    check("t4_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd5);

    // T5: stray done in IDLE, then done coincident with expiry
    bb = byte_q.size(); db = dv_cyc_q.size();
    @(posedge clk); #1;
    stray_cnt++;
    repeat (5) @(negedge clk);
    check("t5_stray_busy", 64'(busy), 64'd0);
    check("t5_stray_nodv", 64'(byte_q.size() - bb), 64'd0);
    check("t5_stray_fc", 64'(frame_cnt), 64'd5);
    @(posedge clk); #1;
    sp_frame = rd_total + 1; sp_idx = 1; sp_delay = TO;
    push(48'h0F1E_2D3C_4B5A);
    wait_drain("t5", 1000);
    check("t5_nbytes", 64'(byte_q.size() - bb), 64'(NB_TX));
    check("t5_byte2", 64'(byte_q[bb+2]), 64'h2D);
    check("t5_dv_gap", 64'(dv_cyc_q[db+2]), 64'(dv_cyc_q[db+1] + TO + 1));
    check("t5_err_cnt", 64'(err_cnt), 64'd1);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd6);

    // T6: checksum frame
    bb = byte_q.size();
    @(posedge clk); #1;
    push(48'hFF00_FF00_1234);
    wait_drain("t6", 1000);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 6; i++) check("t6_byte", 64'(byte_q[bb+i]), 64'(t6_exp[i]));
`ifdef RAH_SERIALIZER_CHECKSUM_EN
    check("t6_nbytes", 64'(byte_q.size() - bb), 64'd7);
    check("t6_trailer", 64'(byte_q[bb+6]), 64'h26);
`else
    check("t6_nbytes", 64'(byte_q.size() - bb), 64'd6);
`endif
    check("t6_frame_cnt", 64'(frame_cnt), 64'd7);
    check("rd_while_empty", 64'(bad_rd), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
